// File: rtl/memory_game_pkg.sv
// Shared types for the card-matching game controller: state encoding,
// auto-reveal card counts and the default score type.
package memory_game_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SHOW    = 4'd1,
    ST_HIDE    = 4'd2,
    ST_SHUFFLE = 4'd3,
    ST_TURN0   = 4'd4,
    ST_TURN1   = 4'd5,
    ST_AUTO    = 4'd6,
    ST_EVAL    = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

  localparam logic [1:0] AUTO_CNT_ONE = 2'd1;
  localparam logic [1:0] AUTO_CNT_TWO = 2'd2;

  localparam int SCORE_W_DEFAULT = 4;
  typedef logic [SCORE_W_DEFAULT-1:0] score_t;

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: reloads on turn entry, counts tick strobes down to zero
// and flags a timeout when a tick arrives with no time left.
module turn_timer #(
  parameter int TURN_TICKS = 15,
  parameter int TW         = $clog2(TURN_TICKS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reload,
  input  logic          run,
  input  logic          tick,
  output logic [TW-1:0] time_left,
  output logic          timeout
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      time_left <= TW'(TURN_TICKS);
    end else if (reload) begin
      time_left <= TW'(TURN_TICKS);
    end else if (run && tick && (time_left != '0)) begin
      time_left <= time_left - 1'b1;
    end
  end

  assign timeout = run && tick && (time_left == '0);

endmodule

// File: rtl/memory_game_ctrl.sv
// Master controller for the card-matching game: N-player turn sequencing,
// board setup handshakes, timeout auto-pick, match evaluation and winner mask.
module memory_game_ctrl
  import memory_game_pkg::*;
#(
  parameter int N_PLAYERS  = 2,
  parameter int N_PAIRS    = 8,
  parameter int SCORE_W    = SCORE_W_DEFAULT,
  parameter int TURN_TICKS = 15,
  parameter int PW         = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1,
  parameter int PFW        = $clog2(N_PAIRS + 1),
  parameter int TW         = $clog2(TURN_TICKS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         tick_i,
  input  logic                         show_done_i,
  input  logic                         hide_done_i,
  input  logic                         shuffle_done_i,
  input  logic                         card_pick_i,
  input  logic                         auto_ack_i,
  input  logic                         match_valid_i,
  input  logic                         match_i,
  output logic [3:0]                   state_o,
  output logic [PW-1:0]                turn_o,
  output logic [N_PLAYERS*SCORE_W-1:0] scores_o,
  output logic [PFW-1:0]               pairs_found_o,
  output logic [TW-1:0]                time_left_o,
  output logic                         auto_req_o,
  output logic [1:0]                   auto_cnt_o,
  output logic                         eval_req_o,
  output logic [N_PLAYERS-1:0]         winner_mask_o,
  output logic                         game_over_o
);

  state_t                       state;
  logic [SCORE_W-1:0]           cur_score;
  logic [N_PLAYERS*SCORE_W-1:0] scores_inc;
  logic [PFW-1:0]               pairs_inc;
  logic                         last_pair;
  logic [PW-1:0]                turn_next;
  logic                         reload;
  logic                         run;
  logic                         timeout;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  // Every player tied at the maximum score is flagged.
  function automatic logic [N_PLAYERS-1:0] win_mask(
    input logic [N_PLAYERS*SCORE_W-1:0] sc
  );
    logic [SCORE_W-1:0]   mx;
    logic [N_PLAYERS-1:0] m;
    mx = '0;
    m  = '0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      if (sc[k*SCORE_W +: SCORE_W] > mx) mx = sc[k*SCORE_W +: SCORE_W];
    end
    for (int k = 0; k < N_PLAYERS; k++) begin
      m[k] = (sc[k*SCORE_W +: SCORE_W] == mx);
    end
    return m;
  endfunction

  always_comb begin
    cur_score  = scores_o[int'(turn_o)*SCORE_W +: SCORE_W];
    scores_inc = scores_o;
    scores_inc[int'(turn_o)*SCORE_W +: SCORE_W] = sat_inc(cur_score);
    pairs_inc  = (pairs_found_o == PFW'(N_PAIRS)) ? pairs_found_o : pairs_found_o + 1'b1;
    last_pair  = (pairs_inc == PFW'(N_PAIRS));
    turn_next  = (turn_o == PW'(N_PLAYERS - 1)) ? '0 : turn_o + 1'b1;
  end

  // The timer reloads on every entry into TURN0, but not on the final match into DONE.
  assign reload = ((state == ST_SHUFFLE) && shuffle_done_i) ||
                  ((state == ST_EVAL) && match_valid_i && !(match_i && last_pair));
  assign run    = (state == ST_TURN0) || (state == ST_TURN1);

  turn_timer #(
    .TURN_TICKS(TURN_TICKS),
    .TW        (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .reload   (reload),
    .run      (run),
    .tick     (tick_i),
    .time_left(time_left_o),
    .timeout  (timeout)
  );

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      turn_o        <= '0;
      scores_o      <= '0;
      pairs_found_o <= '0;
      winner_mask_o <= '0;
      auto_req_o    <= 1'b0;
      auto_cnt_o    <= 2'd0;
      eval_req_o    <= 1'b0;
      game_over_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            scores_o      <= '0;
            pairs_found_o <= '0;
            turn_o        <= '0;
            winner_mask_o <= '0;
            state         <= ST_SHOW;
          end
        end
        ST_SHOW:    if (show_done_i)    state <= ST_HIDE;
        ST_HIDE:    if (hide_done_i)    state <= ST_SHUFFLE;
        ST_SHUFFLE: if (shuffle_done_i) state <= ST_TURN0;
        ST_TURN0: begin
          if (card_pick_i) begin
            state <= ST_TURN1;
          end else if (timeout) begin
            state      <= ST_AUTO;
            auto_req_o <= 1'b1;
            auto_cnt_o <= AUTO_CNT_TWO;
          end
        end
        ST_TURN1: begin
          if (card_pick_i) begin
            state      <= ST_EVAL;
            eval_req_o <= 1'b1;
          end else if (timeout) begin
            state      <= ST_AUTO;
            auto_req_o <= 1'b1;
            auto_cnt_o <= AUTO_CNT_ONE;
          end
        end
        ST_AUTO: begin
          if (auto_ack_i) begin
            auto_req_o <= 1'b0;
            eval_req_o <= 1'b1;
            state      <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (match_valid_i) begin
            eval_req_o <= 1'b0;
            if (match_i) begin
              scores_o      <= scores_inc;
              pairs_found_o <= pairs_inc;
              if (last_pair) begin
                winner_mask_o <= win_mask(scores_inc);
                game_over_o   <= 1'b1;
                state         <= ST_DONE;
              end else begin
                state <= ST_TURN0;
              end
            end else begin
              turn_o <= turn_next;
              state  <= ST_TURN0;
            end
          end
        end
        ST_DONE: begin
          if (start_i) begin
            game_over_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Vector/scoreboard bench for memory_game_ctrl with 3 players and 4 pairs.
module tb_memory_game_ctrl;

  localparam logic [8:0] I_S  = 9'h001;
  localparam logic [8:0] I_T  = 9'h002;
  localparam logic [8:0] I_SH = 9'h004;
  localparam logic [8:0] I_HI = 9'h008;
  localparam logic [8:0] I_SF = 9'h010;
  localparam logic [8:0] I_P  = 9'h020;
  localparam logic [8:0] I_A  = 9'h040;
  localparam logic [8:0] I_MV = 9'h080;
  localparam logic [8:0] I_M  = 9'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, tick_i, show_done_i, hide_done_i, shuffle_done_i;
  logic        card_pick_i, auto_ack_i, match_valid_i, match_i;
  logic [3:0]  state_o;
  logic [1:0]  turn_o;
  logic [11:0] scores_o;
  logic [2:0]  pairs_found_o;
  logic [3:0]  time_left_o;
  logic        auto_req_o;
  logic [1:0]  auto_cnt_o;
  logic        eval_req_o;
  logic [2:0]  winner_mask_o;
  logic        game_over_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] in;
    logic [3:0] st;
    logic [1:0] turn;
    logic       areq;
    logic [1:0] acnt;
    logic       ereq;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];

  memory_game_ctrl #(
    .N_PLAYERS (3),
    .N_PAIRS   (4),
    .SCORE_W   (4),
    .TURN_TICKS(15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .tick_i        (tick_i),
    .show_done_i   (show_done_i),
    .hide_done_i   (hide_done_i),
    .shuffle_done_i(shuffle_done_i),
    .card_pick_i   (card_pick_i),
    .auto_ack_i    (auto_ack_i),
    .match_valid_i (match_valid_i),
    .match_i       (match_i),
    .state_o       (state_o),
    .turn_o        (turn_o),
    .scores_o      (scores_o),
    .pairs_found_o (pairs_found_o),
    .time_left_o   (time_left_o),
    .auto_req_o    (auto_req_o),
    .auto_cnt_o    (auto_cnt_o),
    .eval_req_o    (eval_req_o),
    .winner_mask_o (winner_mask_o),
    .game_over_o   (game_over_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [8:0] in, input int st, input int turn,
                              input bit areq, input int acnt, input bit ereq);
    vec_t v;
    v.in   = in;
    v.st   = 4'(st);
    v.turn = 2'(turn);
    v.areq = areq;
    v.acnt = 2'(acnt);
    v.ereq = ereq;
    return v;
  endfunction

  task automatic drive(input logic [8:0] in);
    start_i        = in[0];
    tick_i         = in[1];
    show_done_i    = in[2];
    hide_done_i    = in[3];
    shuffle_done_i = in[4];
    card_pick_i    = in[5];
    auto_ack_i     = in[6];
    match_valid_i  = in[7];
    match_i        = in[8];
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v.in);
    exp_q.push_back(v);
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin : scoreboard
    vec_t v;
    #1;
    if (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      chk("state", int'(state_o), int'(v.st));
      chk("turn", int'(turn_o), int'(v.turn));
      chk("auto_req", int'(auto_req_o), int'(v.areq));
      chk("eval_req", int'(eval_req_o), int'(v.ereq));
      if (v.areq) chk("auto_cnt", int'(auto_cnt_o), int'(v.acnt));
    end
  end

  initial begin
    rst = 1'b0;
    drive(9'h000);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", int'(state_o), 0);
    chk("rst_turn", int'(turn_o), 0);
    chk("rst_scores", int'(scores_o), 0);
    chk("rst_pairs", int'(pairs_found_o), 0);
    chk("rst_time", int'(time_left_o), 15);
    chk("rst_auto_req", int'(auto_req_o), 0);
    chk("rst_eval_req", int'(eval_req_o), 0);
    chk("rst_mask", int'(winner_mask_o), 0);
    chk("rst_game_over", int'(game_over_o), 0);
    rst = 1'b1;

    // Setup, ignored inputs, then three mismatch rounds rotating the turn.
    tbl.push_back(mk(I_P,  0, 0, 0, 0, 0));
    tbl.push_back(mk(I_S,  1, 0, 0, 0, 0));
    tbl.push_back(mk(I_P,  1, 0, 0, 0, 0));
    tbl.push_back(mk(I_SH, 2, 0, 0, 0, 0));
    tbl.push_back(mk(I_HI, 3, 0, 0, 0, 0));
    tbl.push_back(mk(I_SF, 4, 0, 0, 0, 0));
    tbl.push_back(mk(I_S,  4, 0, 0, 0, 0));
    for (int t = 0; t < 3; t++) begin
      tbl.push_back(mk(I_P,  5, t, 0, 0, 0));
      tbl.push_back(mk(I_P,  7, t, 0, 0, 1));
      if (t == 0) tbl.push_back(mk(9'h000, 7, t, 0, 0, 1));
      tbl.push_back(mk(I_MV, 4, (t + 1) % 3, 0, 0, 0));
    end
    foreach (tbl[i]) apply(tbl[i]);
    sync();
    chk("rounds_time", int'(time_left_o), 15);
    chk("rounds_scores", int'(scores_o), 0);

    // Timeout in TURN1 auto-reveals one card.
    apply(mk(I_P, 5, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++) apply(mk(I_T, 5, 0, 0, 0, 0));
    sync();
    chk("t1_time_zero", int'(time_left_o), 0);
    apply(mk(I_T,    6, 0, 1, 1, 0));
    apply(mk(9'h000, 6, 0, 1, 1, 0));
    apply(mk(I_A,    7, 0, 0, 0, 1));
    apply(mk(I_MV,   4, 1, 0, 0, 0));
    sync();
    chk("t1_reload", int'(time_left_o), 15);

    // Pick and timeout together in TURN0: the pick wins.
    for (int i = 0; i < 15; i++) apply(mk(I_T, 4, 1, 0, 0, 0));
    apply(mk(I_P | I_T, 5, 1, 0, 0, 0));
    sync();
    chk("pick_wins_time", int'(time_left_o), 0);
    apply(mk(I_P,  7, 1, 0, 0, 1));
    apply(mk(I_MV, 4, 2, 0, 0, 0));

    // Timeout in TURN0 auto-reveals two cards.
    for (int i = 0; i < 15; i++) apply(mk(I_T, 4, 2, 0, 0, 0));
    apply(mk(I_T,  6, 2, 1, 2, 0));
    apply(mk(I_A,  7, 2, 0, 0, 1));
    apply(mk(I_MV, 4, 0, 0, 0, 0));

    // Full game: player 0 matches twice, player 1 matches twice.
    for (int r = 0; r < 2; r++) begin
      apply(mk(I_P,        5, 0, 0, 0, 0));
      apply(mk(I_P,        7, 0, 0, 0, 1));
      apply(mk(I_MV | I_M, 4, 0, 0, 0, 0));
    end
    sync();
    chk("p0_scores", int'(scores_o), 12'h002);
    chk("p0_pairs", int'(pairs_found_o), 2);
    apply(mk(I_P,  5, 0, 0, 0, 0));
    apply(mk(I_P,  7, 0, 0, 0, 1));
    apply(mk(I_MV, 4, 1, 0, 0, 0));
    apply(mk(I_P,        5, 1, 0, 0, 0));
    apply(mk(I_P,        7, 1, 0, 0, 1));
    apply(mk(I_MV | I_M, 4, 1, 0, 0, 0));
    sync();
    chk("p1_scores", int'(scores_o), 12'h012);
    apply(mk(I_P,        5, 1, 0, 0, 0));
    apply(mk(I_P,        7, 1, 0, 0, 1));
    apply(mk(I_MV | I_M, 8, 1, 0, 0, 0));
    sync();
    chk("done_scores", int'(scores_o), 12'h022);
    chk("done_pairs", int'(pairs_found_o), 4);
    chk("done_mask", int'(winner_mask_o), 3'b011);
    chk("done_game_over", int'(game_over_o), 1);
    apply(mk(I_P, 8, 1, 0, 0, 0));
    sync();
    chk("done_hold", int'(game_over_o), 1);
    apply(mk(I_S, 0, 1, 0, 0, 0));
    sync();
    chk("idle_scores_kept", int'(scores_o), 12'h022);
    chk("idle_game_over", int'(game_over_o), 0);
    apply(mk(I_S, 1, 0, 0, 0, 0));
    sync();
    chk("restart_scores", int'(scores_o), 0);
    chk("restart_pairs", int'(pairs_found_o), 0);
    chk("restart_mask", int'(winner_mask_o), 0);

    // Reset while AUTO is waiting for its acknowledge.
    apply(mk(I_SH,       2, 0, 0, 0, 0));
    apply(mk(I_HI,       3, 0, 0, 0, 0));
    apply(mk(I_SF,       4, 0, 0, 0, 0));
    apply(mk(I_P,        5, 0, 0, 0, 0));
    apply(mk(I_P,        7, 0, 0, 0, 1));
    apply(mk(I_MV | I_M, 4, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++) apply(mk(I_T, 4, 0, 0, 0, 0));
    apply(mk(I_T, 6, 0, 1, 2, 0));
    @(negedge clk);
    rst = 1'b0;
    drive(9'h000);
    exp_q.push_back(mk(9'h000, 0, 0, 0, 0, 0));
    sync();
    chk("mid_rst_scores", int'(scores_o), 0);
    chk("mid_rst_pairs", int'(pairs_found_o), 0);
    chk("mid_rst_time", int'(time_left_o), 15);
    rst = 1'b1;

    sync();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_game_ctrl.md
Name: memory_game_ctrl

Overview:
Parametrised master controller for the card-matching game. It generalises the two-player turn FSM to N players and P pairs, and integrates the per-turn countdown timer. It adds a board auto-pick handshake on timeout, an explicit match-compare handshake, and a multi-winner tie mask. It sits between the board/VGA datapath (show, hide, shuffle, compare, reveal engines) and the score/timer display logic.

Parameters:
N_PLAYERS, 2, number of players (2..8); PW = max(1, clog2(N_PLAYERS)).
N_PAIRS, 8, pairs on the board (1..32).
SCORE_W, 4, score width per player; must satisfy 2^SCORE_W > N_PAIRS.
TURN_TICKS, 15, tick_i pulses allowed per turn (1..255); TW = clog2(TURN_TICKS+1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start_i  in  1  start pulse (IDLE) / restart pulse (DONE)
tick_i  in  1  one-cycle timebase strobe (e.g. 1 Hz)
show_done_i  in  1  board finished showing all cards
hide_done_i  in  1  board finished hiding all cards
shuffle_done_i  in  1  board finished shuffling
card_pick_i  in  1  one-cycle pulse: player selected a valid face-down card
auto_ack_i  in  1  board finished revealing random cards
match_valid_i  in  1  compare result valid (one cycle)
match_i  in  1  the two revealed cards are a pair (sampled with match_valid_i)
state_o  out  4  current state encoding
turn_o  out  PW  active player index (0-based)
scores_o  out  N_PLAYERS*SCORE_W  packed scores, player k at [k*SCORE_W +: SCORE_W]
pairs_found_o  out  clog2(N_PAIRS+1)  pairs removed so far
time_left_o  out  TW  remaining ticks in the current turn
auto_req_o  out  1  request board to auto-reveal cards
auto_cnt_o  out  2  number of cards to auto-reveal (1 or 2)
eval_req_o  out  1  request board to compare the revealed pair
winner_mask_o  out  N_PLAYERS  bit k set when player k holds the maximum score
game_over_o  out  1  high in DONE

Behaviour:
- Reset (rst=0 at posedge clk): state IDLE; turn_o=0; scores, pairs_found_o, winner_mask_o=0; time_left_o=TURN_TICKS; all request outputs and game_over_o=0. Reset mid-game aborts immediately; no handshake completes.
- All outputs are registered.
- State encoding: IDLE=0, SHOW=1, HIDE=2, SHUFFLE=3, TURN0=4, TURN1=5, AUTO=6, EVAL=7, DONE=8. Unused codes go to IDLE.
- IDLE: on start_i, clear scores, pairs, turn and mask, then go to SHOW.
- SHOW -> HIDE on show_done_i. HIDE -> SHUFFLE on hide_done_i. SHUFFLE -> TURN0 on shuffle_done_i.
- Timer reload: every entry into TURN0 loads time_left_o with TURN_TICKS.
- Timer countdown: in TURN0 and TURN1, tick_i decrements time_left_o; it never wraps below 0. The timer keeps running across the first pick.
- TURN0: card_pick_i -> TURN1. Timeout (tick_i while time_left_o==0) -> AUTO with auto_cnt_o=2.
- TURN1: card_pick_i -> EVAL. Timeout -> AUTO with auto_cnt_o=1.
- Simultaneous card_pick_i and timeout: the pick wins.
- AUTO: auto_req_o held high until auto_ack_i, then go to EVAL. auto_cnt_o is stable throughout AUTO.
- EVAL: eval_req_o held high until match_valid_i.
  - match_i=1: scores[turn] += 1 and pairs_found += 1, both saturating. Same player keeps the turn. If the new pairs_found == N_PAIRS, go to DONE; else go to TURN0.
  - match_i=0: turn_o = (turn_o+1) wrapping at N_PLAYERS-1 -> 0, then go to TURN0.
- card_pick_i outside TURN0/TURN1 is ignored. start_i outside IDLE/DONE is ignored.
- DONE entry (one cycle after the last match): winner_mask_o set for every player whose score equals the maximum (ties set several bits); game_over_o=1.
- DONE: outputs hold until start_i; start_i returns to IDLE with scores retained until the IDLE->SHOW clear.
- Latency: each transition takes effect on the clock edge that samples its input; outputs change the following cycle.

Decomposition:
- Package memory_game_pkg: state_t enum with the fixed encodings above, AUTO_CNT constants, and a score_t typedef sized by SCORE_W.
- Sub-module turn_timer: reload, tick decrement, saturation at 0, timeout flag; TURN_TICKS parameter. The controller instantiates it once.
- Winner-mask max-reduction stays a combinational function in the controller.

Test Plan:
- Setup sequence: reset, start_i, then show/hide/shuffle done pulses -> state_o goes 1,2,3,4; time_left_o=15; turn_o=0.
- No match, N_PLAYERS=3: three picks-plus-mismatch rounds -> turn_o goes 1,2,0; all scores 0.
- Timeout in TURN1: pick once, then 16 ticks -> auto_req_o=1 with auto_cnt_o=1; auto_ack_i -> eval_req_o=1. A mismatch advances turn_o.
- Pick and timeout in the same cycle: card_pick_i and tick_i together with time_left_o=0 in TURN0 -> state_o=5 and no auto_req_o.
- Full game, N_PAIRS=4: player 0 matches 2, player 1 matches 2 -> DONE, winner_mask_o=2'b11, game_over_o=1. start_i returns to IDLE; the next start_i clears scores.
- Reset mid-AUTO: rst=0 while auto_req_o=1 -> next cycle state_o=0, auto_req_o=0, scores 0.
